fg_dac_ctrl: RTL and testbench

- Sequencer between the function generator sample stream and the external parallel DAC.
- Runs the DAC power-up sequence: clear, then wake and settle.
- Converts the one-cycle sample-valid strobe into a DAC write cycle with timing-compliant setup, WR-low and hold phases, and buffers one sample that arrives while a write is in flight.
- Controls DAC power-down on request; drives the dac_* pins of the top level directly.

---
 rtl/fg_pkg.sv | 20 ++
 rtl/fg_dac_timer.sv | 30 +++
 rtl/fg_dac_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_fg_dac_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fg_pkg.sv
// Shared definitions for the function-generator DAC sequencer: state encoding
// and the default DAC timing constants.
package fg_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_WAKE  = 3'd1,
    ST_IDLE  = 3'd2,
    ST_SETUP = 3'd3,
    ST_WR    = 3'd4,
    ST_HOLD  = 3'd5,
    ST_SLEEP = 3'd6
  } fg_state_t;

  localparam int DEF_CLR_CYCLES   = 4;
  localparam int DEF_WAKE_CYCLES  = 16;
  localparam int DEF_SETUP_CYCLES = 1;
  localparam int DEF_WR_CYCLES    = 2;

endpackage

// File: rtl/fg_dac_timer.sv
// Loadable down-counter with a zero flag; times the CLEAR, WAKE, SETUP and WR
// phases of the DAC sequencer.
module fg_dac_timer #(
  parameter int CNT_BITWIDTH = 5
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_load,
  input  logic [CNT_BITWIDTH-1:0] i_load_val,
  input  logic                    i_dec,
  output logic                    o_zero
);

  logic [CNT_BITWIDTH-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/fg_dac_ctrl.sv
// DAC sequencer: power-up clear/wake, strobe-to-write-cycle conversion with a
// one-deep pending buffer, and sleep control. FG_DAC_DROP_CNT_EN adds a drop counter.
module fg_dac_ctrl
  import fg_pkg::*;
#(
  parameter int BITWIDTH     = 8,
  parameter int CLR_CYCLES   = DEF_CLR_CYCLES,
  parameter int WAKE_CYCLES  = DEF_WAKE_CYCLES,
  parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
  parameter int WR_CYCLES    = DEF_WR_CYCLES,
  parameter int CNT_BITWIDTH = 5
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                enable_i,
  input  logic                sleep_i,
  input  logic [BITWIDTH-1:0] sample_i,
  input  logic                sample_valid_i,
`ifdef FG_DAC_DROP_CNT_EN
  input  logic                drop_clr_i,
  output logic [7:0]          drop_cnt_o,
`endif
  output logic [BITWIDTH-1:0] dac_data_o,
  output logic                dac_wr_n_o,
  output logic                dac_clr_n_o,
  output logic                dac_pd_n_o,
  output logic                ready_o,
  output logic                busy_o
);

  // Each phase loads N-1 on entry and leaves when the timer reads zero. CLEAR is
  // entered straight from reset with the counter at 0, so its first cycle is the load.
  localparam logic [CNT_BITWIDTH-1:0] LD_CLR   =
    (CLR_CYCLES > 1) ? CNT_BITWIDTH'(CLR_CYCLES - 2) : '0;
  localparam logic [CNT_BITWIDTH-1:0] LD_WAKE  = CNT_BITWIDTH'(WAKE_CYCLES - 1);
  localparam logic [CNT_BITWIDTH-1:0] LD_SETUP = CNT_BITWIDTH'(SETUP_CYCLES - 1);
  localparam logic [CNT_BITWIDTH-1:0] LD_WR    = CNT_BITWIDTH'(WR_CYCLES - 1);

  fg_state_t             r_state;
  logic                  r_armed;
  logic                  r_pend_full;
  logic [BITWIDTH-1:0]   r_pend_data;

  logic                    w_strobe;
  logic                    w_zero;
  logic                    w_clr_done;
  logic                    w_pend_wr;
  logic                    w_load;
  logic                    w_dec;
  logic [CNT_BITWIDTH-1:0] w_load_val;

  assign w_strobe   = sample_valid_i & enable_i;
  assign w_clr_done = r_armed ? w_zero : (CLR_CYCLES == 1);
  assign w_pend_wr  = w_strobe & ((r_state == ST_SETUP) | (r_state == ST_WR) |
                                  ((r_state == ST_HOLD) & r_pend_full));

  fg_dac_timer #(
    .CNT_BITWIDTH(CNT_BITWIDTH)
  ) u_timer (
    .i_clk      (clk_i),
    .i_rstn     (rstn_i),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    w_dec      = 1'b0;
    unique case (r_state)
      ST_CLEAR: begin
        if (w_clr_done) begin
          w_load     = 1'b1;
          w_load_val = LD_WAKE;
        end else if (!r_armed) begin
          w_load     = 1'b1;
          w_load_val = LD_CLR;
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_WAKE, ST_WR: w_dec = 1'b1;
      ST_IDLE: begin
        w_load     = w_strobe;
        w_load_val = LD_SETUP;
      end
      ST_SETUP: begin
        w_load     = w_zero;
        w_load_val = LD_WR;
        w_dec      = ~w_zero;
      end
      ST_HOLD: begin
        w_load     = r_pend_full | w_strobe;
        w_load_val = LD_SETUP;
      end
      ST_SLEEP: begin
        w_load     = ~sleep_i;
        w_load_val = LD_WAKE;
      end
      default: ;
    endcase
  end

  // NOTE: the pending data register is reset along with everything else; it is a
  // single word, so a defined value after reset costs nothing and eases debug.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= ST_CLEAR;
      r_armed     <= 1'b0;
      r_pend_full <= 1'b0;
      r_pend_data <= '0;
      dac_data_o  <= '0;
      dac_wr_n_o  <= 1'b1;
      dac_clr_n_o <= 1'b0;
      dac_pd_n_o  <= 1'b1;
      ready_o     <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      unique case (r_state)
        ST_CLEAR: begin
          r_armed <= 1'b1;
          if (w_clr_done) begin
            dac_clr_n_o <= 1'b1;
            r_state     <= ST_WAKE;
          end
        end
        ST_WAKE: begin
          if (w_zero) begin
            r_state <= ST_IDLE;
            ready_o <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (w_strobe) begin
            dac_data_o <= sample_i;
            busy_o     <= 1'b1;
            r_state    <= ST_SETUP;
          end else if (sleep_i) begin
            dac_pd_n_o <= 1'b0;
            ready_o    <= 1'b0;
            r_state    <= ST_SLEEP;
          end
        end
        ST_SETUP: begin
          if (w_zero) begin
            dac_wr_n_o <= 1'b0;
            r_state    <= ST_WR;
          end
        end
        ST_WR: begin
          if (w_zero) begin
            dac_wr_n_o <= 1'b1;
            r_state    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (r_pend_full) begin
            dac_data_o  <= r_pend_data;
            r_pend_full <= 1'b0;
            r_state     <= ST_SETUP;
          end else if (w_strobe) begin
            dac_data_o <= sample_i;
            r_state    <= ST_SETUP;
          end else begin
            busy_o  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_SLEEP: begin
          if (!sleep_i) begin
            dac_pd_n_o <= 1'b1;
            r_state    <= ST_WAKE;
          end
        end
        default: r_state <= ST_CLEAR;
      endcase
      // Newest strobe wins; in HOLD this refills the slot being drained.
      if (w_pend_wr) begin
        r_pend_data <= sample_i;
        r_pend_full <= 1'b1;
      end
    end
  end

`ifdef FG_DAC_DROP_CNT_EN
  logic w_drop;
  assign w_drop = w_strobe & r_pend_full & ((r_state == ST_SETUP) | (r_state == ST_WR));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      drop_cnt_o <= 8'd0;
    end else if (drop_clr_i) begin
      drop_cnt_o <= 8'd0;
    end else if (w_drop && (drop_cnt_o != 8'hFF)) begin
      drop_cnt_o <= drop_cnt_o + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fg_dac_ctrl.sv
// Self-checking bench for fg_dac_ctrl: directed scenarios plus random stimulus,
// all compared cycle by cycle against a transaction-level reference model.
module tb_fg_dac_ctrl;

  localparam int BW = 8;
  localparam int C  = 4;
  localparam int WK = 16;
  localparam int S  = 1;
  localparam int W  = 2;

  logic          clk_i          = 1'b0;
  logic          rstn_i         = 1'b1;
  logic          enable_i       = 1'b1;
  logic          sleep_i        = 1'b0;
  logic          sample_valid_i = 1'b0;
  logic [BW-1:0] sample_i       = '0;
  logic [BW-1:0] dac_data_o;
  logic          dac_wr_n_o, dac_clr_n_o, dac_pd_n_o, ready_o, busy_o;
`ifdef FG_DAC_DROP_CNT_EN
  logic          drop_clr_i = 1'b0;
  logic [7:0]    drop_cnt_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  fg_dac_ctrl #(
    .BITWIDTH(BW), .CLR_CYCLES(C), .WAKE_CYCLES(WK),
    .SETUP_CYCLES(S), .WR_CYCLES(W), .CNT_BITWIDTH(5)
  ) dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .enable_i       (enable_i),
    .sleep_i        (sleep_i),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
`ifdef FG_DAC_DROP_CNT_EN
    .drop_clr_i     (drop_clr_i),
    .drop_cnt_o     (drop_cnt_o),
`endif
    .dac_data_o     (dac_data_o),
    .dac_wr_n_o     (dac_wr_n_o),
    .dac_clr_n_o    (dac_clr_n_o),
    .dac_pd_n_o     (dac_pd_n_o),
    .ready_o        (ready_o),
    .busy_o         (busy_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a write accepted at edge k drives WR low after edges
  // k+S .. k+S+W-1 and ends at edge k+S+W+1 with the HOLD decision.
  int            n, ready_at, cur_k, drops;
  bit            asleep;
  logic [BW-1:0] m_data;
  logic [BW-1:0] pend_q[$];

  task automatic model_reset();
    n = 0; ready_at = C + WK; cur_k = -1; drops = 0;
    asleep = 1'b0; m_data = '0; pend_q.delete();
  endtask

  task automatic model_step(input bit stb, input bit slp, input logic [BW-1:0] smp);
    n++;
    if (cur_k >= 0 && n == cur_k + S + W + 1) begin
      if (pend_q.size() > 0) begin
        m_data = pend_q.pop_front();
        cur_k  = n;
        if (stb) pend_q.push_back(smp);
      end else if (stb) begin
        m_data = smp;
        cur_k  = n;
      end else begin
        cur_k = -1;
      end
    end else if (cur_k >= 0) begin
      if (stb) begin
        if (pend_q.size() > 0) begin
          pend_q.delete();
          if (drops < 255) drops++;
        end
        pend_q.push_back(smp);
      end
    end else if (asleep) begin
      if (!slp) begin
        asleep   = 1'b0;
        ready_at = n + WK;
      end
    end else if (n > ready_at) begin
      if (stb) begin
        m_data = smp;
        cur_k  = n;
      end else if (slp) begin
        asleep = 1'b1;
      end
    end
  endtask

  always @(posedge clk_i) begin
    if (!rstn_i) begin
      model_reset();
    end else begin
      model_step(sample_valid_i & enable_i, sleep_i, sample_i);
      #1;
      if (rstn_i) begin
        check("wr_n",  dac_wr_n_o, !(cur_k >= 0 && n >= cur_k + S && n < cur_k + S + W));
        check("data",  dac_data_o, m_data);
        check("clr_n", dac_clr_n_o, n >= C);
        check("pd_n",  dac_pd_n_o, !asleep);
        check("ready", ready_o, !asleep && n >= ready_at);
        check("busy",  busy_o, cur_k >= 0 || pend_q.size() > 0);
`ifdef FG_DAC_DROP_CNT_EN
        check("drop_cnt", drop_cnt_o, drops);
`endif
      end
    end
  end

  logic [BW-1:0] wr_log[$];
  always @(negedge dac_wr_n_o) wr_log.push_back(dac_data_o);

  task automatic cyc(input logic v, input logic [BW-1:0] d, input logic slp);
    sample_valid_i = v;
    sample_i       = d;
    sleep_i        = slp;
    @(posedge clk_i);
    #2;
    sample_valid_i = 1'b0;
  endtask

  int  base;
  bit  slp_r;

  initial begin
    #1 rstn_i = 1'b0;
    #1;
    check("rst_wr_n",  dac_wr_n_o, 1'b1);
    check("rst_clr_n", dac_clr_n_o, 1'b0);
    repeat (3) @(posedge clk_i);
    #7 rstn_i = 1'b1;
    wr_log.delete();

    // Init sequence with strobes that must be ignored
    for (int i = 0; i < 18; i++) cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
    repeat (4) cyc(1'b0, 8'h00, 1'b0);
    check("t1_no_write", wr_log.size(), 0);
    check("t1_ready", ready_o, 1'b1);

    // Single write timing
    cyc(1'b1, 8'hA5, 1'b0);
    check("t2_data_k", dac_data_o, 8'hA5);
    check("t2_busy_k", busy_o, 1'b1);
    check("t2_wr_k", dac_wr_n_o, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    check("t2_wr_k1", dac_wr_n_o, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    check("t2_wr_k2", dac_wr_n_o, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    check("t2_wr_k3", dac_wr_n_o, 1'b1);
    check("t2_busy_k3", busy_o, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    check("t2_busy_k4", busy_o, 1'b0);
    check("t2_logged", wr_log[wr_log.size() - 1], 8'hA5);

    // Back-to-back: middle sample is overwritten
    base = wr_log.size();
    cyc(1'b1, 8'h11, 1'b0);
    cyc(1'b1, 8'h22, 1'b0);
    cyc(1'b1, 8'h33, 1'b0);
    repeat (8) cyc(1'b0, 8'h00, 1'b0);
    check("t3_count", wr_log.size(), base + 2);
    check("t3_first", wr_log[base], 8'h11);
    check("t3_second", wr_log[base + 1], 8'h33);
`ifdef FG_DAC_DROP_CNT_EN
    check("t3_drop_cnt", drop_cnt_o, 8'd1);
`endif

    // Minimum sample period stream
    base = wr_log.size();
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      repeat (3) cyc(1'b0, 8'h00, 1'b0);
    end
    repeat (4) cyc(1'b0, 8'h00, 1'b0);
    check("t4_count", wr_log.size(), base + 20);
    for (int i = 0; i < 20; i++) check("t4_order", wr_log[base + i], 8'(i));

    // Sleep requested mid-write with a sample pending
    base = wr_log.size();
    cyc(1'b1, 8'h55, 1'b0);
    cyc(1'b1, 8'h66, 1'b1);
    repeat (14) cyc(1'b0, 8'h00, 1'b1);
    check("t5_count", wr_log.size(), base + 2);
    check("t5_last", wr_log[base + 1], 8'h66);
    check("t5_pd_n", dac_pd_n_o, 1'b0);
    check("t5_ready", ready_o, 1'b0);
    repeat (20) cyc(1'b0, 8'h00, 1'b0);
    check("t5_wake_ready", ready_o, 1'b1);
    check("t5_wake_clr_n", dac_clr_n_o, 1'b1);

    // Asynchronous reset during WR
    base = wr_log.size();
    cyc(1'b1, 8'hC3, 1'b0);
    cyc(1'b1, 8'h3C, 1'b0);
    check("t6_wr_low", dac_wr_n_o, 1'b0);
    rstn_i = 1'b0;
    #1;
    check("t6_rst_wr_n", dac_wr_n_o, 1'b1);
    check("t6_rst_data", dac_data_o, 8'h00);
    check("t6_rst_busy", busy_o, 1'b0);
    repeat (2) cyc(1'b0, 8'h00, 1'b0);
    rstn_i = 1'b1;
    repeat (25) cyc(1'b0, 8'h00, 1'b0);
    check("t6_pending_lost", wr_log.size(), base + 1);
    check("t6_ready", ready_o, 1'b1);

    // Random traffic with sleep episodes and enable gating
    slp_r = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 29) == 0) slp_r = ~slp_r;
      enable_i = ($urandom_range(0, 7) != 0);
      cyc(($urandom_range(0, 2) == 0), 8'($urandom), slp_r);
    end
    enable_i = 1'b1;
    repeat (25) cyc(1'b0, 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
